// File: rtl/tank_pkg.sv
// Purpose : shared constants and types for the own-tank position UART frame (framer and receiver).
// Latency : n/a (package only).
// Backpressure: n/a. Optional feature macro: TANK_FRAME_CHECKSUM_EN (adds XOR checksum byte B4).
package tank_pkg;

   localparam int POS_W = 10;
   localparam int DIR_W = 2;

   localparam logic [7:0] HEADER_BYTE = 8'hA5;

   localparam int FRAME_LEN_BASE = 4;
   localparam int FRAME_LEN_CSUM = 5;

`ifdef TANK_FRAME_CHECKSUM_EN
   localparam int FRAME_LEN   = FRAME_LEN_CSUM;
   localparam int FRAME_IDX_W = 3;
`else
   localparam int FRAME_LEN   = FRAME_LEN_BASE;
   localparam int FRAME_IDX_W = 2;
`endif

   // Power-on position of the own tank; the receiver uses the same values.
   localparam int X_POS_0 = 300;
   localparam int Y_POS_0 = 5;

   typedef enum logic [DIR_W-1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   // Field order gives the flat vector {x, y, dir}.
   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
      logic [DIR_W-1:0] dir;
   } pos_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } frame_state_e;

   // Byte idx of the frame built from snapshot s.
   function automatic logic [7:0] frame_byte(input pos_t s,
                                             input logic [FRAME_IDX_W-1:0] idx,
                                             input logic [7:0] hdr);
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] b3;
      logic [7:0] res;
      b1  = s.x[9:2];
      b2  = {s.x[1:0], s.y[9:4]};
      b3  = {s.y[3:0], s.dir, 2'b00};
      res = 8'h00;
      case (idx)
         FRAME_IDX_W'(0): res = hdr;
         FRAME_IDX_W'(1): res = b1;
         FRAME_IDX_W'(2): res = b2;
         FRAME_IDX_W'(3): res = b3;
`ifdef TANK_FRAME_CHECKSUM_EN
         FRAME_IDX_W'(4): res = b1 ^ b2 ^ b3;
`endif
         default:         res = 8'h00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/tank_frame_refresh_timer.sv
// Purpose : free-running refresh counter and refresh_pending flag that forces periodic position frames.
// Latency : refresh_pending rises on the edge where the counter wraps, or on any edge while in menu mode.
// Backpressure: none; the counter runs regardless of the frame in flight.
// Ports: clk, rst (sync, active-low), select_mode (count enable; 0 clears counter and arms pending),
//        frame_start (clears pending), refresh_pending (request for one frame).
module tank_frame_refresh_timer #(
   parameter int REFRESH_CYCLES = 1000000,
   parameter int TIMER_W        = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic select_mode,
   input  logic frame_start,
   output logic refresh_pending
);

   logic [TIMER_W-1:0] timer;
   logic               wrap;

   assign wrap = select_mode && (timer == TIMER_W'(REFRESH_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         timer           <= '0;
         refresh_pending <= 1'b1;
      end else begin
         if (!select_mode || wrap) begin
            timer <= '0;
         end else begin
            timer <= timer + TIMER_W'(1);
         end
         // Holding pending set in menu mode makes the first game-mode cycle send a frame.
         // A wrap coinciding with a frame start wins, giving at most one extra frame.
         if (wrap || !select_mode) begin
            refresh_pending <= 1'b1;
         end else if (frame_start) begin
            refresh_pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tank_pos_uart_framer.sv
// Purpose : packs own-tank {x, y, dir} into a HEADER-led byte frame and streams it to the UART TX.
// Latency : first byte valid 1 cycle after a change/refresh trigger; one byte per accepted handshake.
// Backpressure: tx_valid/tx_data hold while tx_ready is low; inputs are ignored until the frame ends.
// Ports: clk, rst (sync, active-low), select_mode (1 = game, frames enabled), xpos_tank/ypos_tank/
//        direction_tank (position in), tx_ready/tx_valid/tx_data (byte handshake to UART),
//        frame_done (pulse after last byte accepted), busy (frame in progress).
// Optional macro TANK_FRAME_CHECKSUM_EN appends B4 = B1 ^ B2 ^ B3.
module tank_pos_uart_framer
   import tank_pkg::*;
#(
   parameter logic [7:0] HEADER         = HEADER_BYTE,
   parameter int         REFRESH_CYCLES = 1000000,
   parameter int         TIMER_W        = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             select_mode,
   input  logic [POS_W-1:0] xpos_tank,
   input  logic [POS_W-1:0] ypos_tank,
   input  logic [DIR_W-1:0] direction_tank,
   input  logic             tx_ready,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   output logic             frame_done,
   output logic             busy
);

   localparam logic [FRAME_IDX_W-1:0] LAST_IDX = FRAME_IDX_W'(FRAME_LEN - 1);

   frame_state_e           state;
   frame_state_e           state_nxt;
   logic [FRAME_IDX_W-1:0] idx;
   pos_t                   cur;
   pos_t                   snap;
   pos_t                   last_sent;
   logic                   refresh_pending;
   logic                   changed;
   logic                   start;
   logic                   accept;
   logic                   last_byte;

   assign cur       = '{x: xpos_tank, y: ypos_tank, dir: direction_tank};
   assign changed   = (cur != last_sent);
   assign start     = (state == IDLE) && select_mode && (changed || refresh_pending);
   assign accept    = (state == SEND) && tx_ready;
   assign last_byte = (idx == LAST_IDX);

   tank_frame_refresh_timer #(
      .REFRESH_CYCLES (REFRESH_CYCLES),
      .TIMER_W        (TIMER_W)
   ) u_refresh (
      .clk             (clk),
      .rst             (rst),
      .select_mode     (select_mode),
      .frame_start     (start),
      .refresh_pending (refresh_pending)
   );

   // State register plus the frame datapath registers that move with it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         snap      <= '0;
         last_sent <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            // The snapshot freezes the frame; later input changes wait for the next frame.
            snap      <= cur;
            last_sent <= cur;
            idx       <= '0;
         end else if (accept && !last_byte) begin
            idx <= idx + FRAME_IDX_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SEND;
         SEND:    if (accept && last_byte) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode registered state only, so they change just on clock edges.
   always_comb begin
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      frame_done = 1'b0;
      busy       = 1'b0;
      case (state)
         SEND: begin
            tx_valid = 1'b1;
            tx_data  = frame_byte(snap, idx, HEADER);
            busy     = 1'b1;
         end
         DONE: begin
            frame_done = 1'b1;
            busy       = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tank_pos_uart_framer.sv
// Purpose : directed bench for tank_pos_uart_framer with a byte scoreboard.
// Latency : n/a.
// Backpressure: stalls tx_ready during a frame and checks the held byte.
module tb_tank_pos_uart_framer;

`ifdef TANK_FRAME_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int FLEN = CSUM ? 5 : 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       select_mode;
   logic [9:0] xpos_tank;
   logic [9:0] ypos_tank;
   logic [1:0] direction_tank;
   logic       tx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       frame_done;
   logic       busy;

   always #5 clk = ~clk;

   tank_pos_uart_framer #(
      .HEADER         (8'hA5),
      .REFRESH_CYCLES (100),
      .TIMER_W        (24)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .select_mode    (select_mode),
      .xpos_tank      (xpos_tank),
      .ypos_tank      (ypos_tank),
      .direction_tank (direction_tank),
      .tx_ready       (tx_ready),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .frame_done     (frame_done),
      .busy           (busy)
   );

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         byte_cnt = 0;
   int         last_done_cyc = 0;
   logic [7:0] sb[$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_dat = 8'h00;

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic checkn(input string tag, input int obs, input int exp);
      tests++;
      assert (obs == exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Literal frame bytes; b4 is only queued in the checksum build.
   task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4);
      sb.push_back(b0);
      sb.push_back(b1);
      sb.push_back(b2);
      sb.push_back(b3);
      if (CSUM) sb.push_back(b4);
   endtask

   // Reference frame from position fields.
   task automatic push_frame(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] b3;
      b1 = x[9:2];
      b2 = {x[1:0], y[9:4]};
      b3 = {y[3:0], d, 2'b00};
      push_bytes(8'hA5, b1, b2, b3, b1 ^ b2 ^ b3);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int start;
      bit got;
      start = done_cnt;
      got   = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_cnt > start) begin
            got = 1'b1;
            break;
         end
      end
      tests++;
      assert (got) else begin
         fails++;
         $error("FAIL %s: observed no frame_done, expected one within %0d cycles", tag, budget);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: every accepted byte must match the scoreboard head; stalled bytes must hold.
   always @(negedge clk) begin
      if (prev_stall) begin
         check1("stall_hold_vld", tx_valid, 1'b1);
         check8("stall_hold_dat", tx_data, prev_dat);
      end
      if (tx_valid && tx_ready) begin
         byte_cnt++;
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_byte: observed %02h expected no byte", tx_data);
         end
         if (sb.size() != 0) check8("byte", tx_data, sb.pop_front());
      end
      prev_stall = rst && tx_valid && !tx_ready;
      prev_dat   = tx_data;
      if (frame_done) begin
         done_cnt++;
         last_done_cyc = cyc;
         check1("done_busy", busy, 1'b1);
         check1("done_vld", tx_valid, 1'b0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int bc;
      int dc;

      // Reset held with game mode on.
      rst            = 1'b0;
      select_mode    = 1'b1;
      tx_ready       = 1'b1;
      xpos_tank      = 10'd300;
      ypos_tank      = 10'd5;
      direction_tank = 2'd1;
      repeat (3) step();
      check1("rst_vld", tx_valid, 1'b0);
      check8("rst_dat", tx_data, 8'h00);
      check1("rst_done", frame_done, 1'b0);
      check1("rst_busy", busy, 1'b0);

      // Basic frame straight out of reset.
      push_bytes(8'hA5, 8'h4B, 8'h00, 8'h54, 8'h1F);
      rst = 1'b1;
      step();
      check1("t2_first_vld", tx_valid, 1'b1);
      check8("t2_first_dat", tx_data, 8'hA5);
      check1("t2_busy", busy, 1'b1);
      repeat (FLEN) step();
      check1("t2_done_pulse", frame_done, 1'b1);
      step();
      check1("t2_done_low", frame_done, 1'b0);
      check1("t2_busy_low", busy, 1'b0);
      select_mode = 1'b0;
      step();
      checkn("t2_sb_empty", sb.size(), 0);

      // Corner values with a 5-cycle stall on B2.
      xpos_tank      = 10'd719;
      ypos_tank      = 10'd702;
      direction_tank = 2'd3;
      push_bytes(8'hA5, 8'hB3, 8'hEB, 8'hEC, 8'hB4);
      select_mode = 1'b1;
      step();
      check8("t3_b0", tx_data, 8'hA5);
      step();
      step();
      check8("t3_b2", tx_data, 8'hEB);
      tx_ready = 1'b0;
      repeat (5) begin
         step();
         check1("t3_stall_vld", tx_valid, 1'b1);
         check8("t3_stall_dat", tx_data, 8'hEB);
      end
      tx_ready = 1'b1;
      wait_done("t3_done", 20);
      select_mode = 1'b0;
      step();
      checkn("t3_sb_empty", sb.size(), 0);

      // Input change while B1 is on the wire.
      xpos_tank      = 10'd300;
      ypos_tank      = 10'd5;
      direction_tank = 2'd1;
      push_bytes(8'hA5, 8'h4B, 8'h00, 8'h54, 8'h1F);
      select_mode = 1'b1;
      step();
      step();
      check8("t4_b1", tx_data, 8'h4B);
      xpos_tank = 10'd301;
      push_bytes(8'hA5, 8'h4B, 8'h40, 8'h54, 8'h5F);
      wait_done("t4_first_done", 20);
      check1("t4_gap_busy", busy, 1'b0);
      check1("t4_gap_vld", tx_valid, 1'b0);
      step();
      check1("t4_second_vld", tx_valid, 1'b1);
      check8("t4_second_dat", tx_data, 8'hA5);
      wait_done("t4_second_done", 20);
      select_mode = 1'b0;
      step();
      checkn("t4_sb_empty", sb.size(), 0);

      // Periodic refresh with static inputs.
      push_frame(10'd301, 10'd5, 2'd1);
      select_mode = 1'b1;
      wait_done("t5_initial", 20);
      t0 = last_done_cyc;
      push_frame(10'd301, 10'd5, 2'd1);
      wait_done("t5_refresh1", 150);
      checkn("t5_period1", last_done_cyc - t0, 100);
      t0 = last_done_cyc;
      push_frame(10'd301, 10'd5, 2'd1);
      wait_done("t5_refresh2", 150);
      checkn("t5_period2", last_done_cyc - t0, 100);
      select_mode = 1'b0;
      step();
      checkn("t5_sb_empty", sb.size(), 0);

      // Menu mode: nothing sent even as the position moves.
      bc = byte_cnt;
      dc = done_cnt;
      for (int i = 0; i < 1000; i++) begin
         if (i % 100 == 0) xpos_tank = xpos_tank + 10'd7;
         step();
      end
      checkn("t6_menu_bytes", byte_cnt, bc);
      checkn("t6_menu_frames", done_cnt, dc);

      // Game mode dropped during B2: frame still completes, nothing follows.
      xpos_tank      = 10'd100;
      ypos_tank      = 10'd200;
      direction_tank = 2'd2;
      push_frame(10'd100, 10'd200, 2'd2);
      select_mode = 1'b1;
      step();
      step();
      step();
      check1("t6_drop_busy", busy, 1'b1);
      select_mode = 1'b0;
      wait_done("t6_drop_done", 20);
      step();
      checkn("t6_drop_sb_empty", sb.size(), 0);
      dc = done_cnt;
      repeat (30) step();
      checkn("t6_drop_no_new", done_cnt, dc);

      // Reset during B1 abandons the frame; a full frame restarts from HEADER.
      xpos_tank      = 10'd5;
      ypos_tank      = 10'd6;
      direction_tank = 2'd0;
      sb.push_back(8'hA5);
      select_mode = 1'b1;
      step();
      step();
      check8("t6_rst_b1", tx_data, 8'h01);
      rst      = 1'b0;
      tx_ready = 1'b0;
      step();
      check1("t6_rst_vld", tx_valid, 1'b0);
      check1("t6_rst_busy", busy, 1'b0);
      check8("t6_rst_dat", tx_data, 8'h00);
      checkn("t6_rst_sb_empty", sb.size(), 0);
      rst      = 1'b1;
      tx_ready = 1'b1;
      push_frame(10'd5, 10'd6, 2'd0);
      step();
      check1("t6_restart_vld", tx_valid, 1'b1);
      check8("t6_restart_dat", tx_data, 8'hA5);
      wait_done("t6_restart_done", 20);
      step();
      checkn("t6_final_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
